eeg_band_power: RTL and testbench

Downstream stage of the EEG band-pass FIR filter. It consumes the 32-bit signed filtered stream and computes the mean-square power over non-overlapping windows of 2^WIN_LOG2 samples. Each result is presented on a ready/valid output together with a band-activity detect flag, for the classifier and UART framer that follow.

---
 rtl/eeg_dsp_pkg.sv | 24 ++
 rtl/bp_square_stage.sv | 48 ++++
 rtl/eeg_band_power.sv | 134 +++++++++++++
 tb/tb_eeg_band_power.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/eeg_dsp_pkg.sv
// Shared EEG DSP definitions: datapath widths, output-FSM states and the
// 16-bit saturation helper used by both the FIR input path and band power.
package eeg_dsp_pkg;

    localparam int FILT_W   = 32;
    localparam int SAMPLE_W = 16;
    localparam int POWER_W  = 32;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Clamp a filter-width value into the signed 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [FILT_W-1:0] x);
        if (x > 32'sd32767)
            return 16'sh7FFF;
        else if (x < -32'sd32768)
            return 16'sh8000;
        else
            return x[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/bp_square_stage.sv
// Band-power front end: S1 shift + saturate, S2 square. The valid bit travels
// alongside the data so gaps in the input stream simply propagate.
module bp_square_stage
    import eeg_dsp_pkg::*;
#(
    parameter int IN_SHIFT = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [FILT_W-1:0] x_i,
    input  logic                     vld_i,
    output logic [POWER_W-1:0]       sq_o,
    output logic                     vld_o
);

    localparam int STAGES = 2;

    logic [STAGES-1:0]          vld_pipe_q;
    logic signed [SAMPLE_W-1:0] s_q, s_d;
    logic [POWER_W-1:0]         sq_q, sq_d;
    logic signed [FILT_W-1:0]   shifted;
    logic signed [POWER_W-1:0]  prod;

    assign shifted = x_i >>> IN_SHIFT;
    assign s_d     = sat16(shifted);
    // Operands widened first so the full 16x16 product is kept; -32768^2 still fits.
    assign prod    = 32'(s_q) * 32'(s_q);
    assign sq_d    = prod;

    // Pipeline registers; data only moves when its stage holds a valid sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            s_q        <= '0;
            sq_q       <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], vld_i};
            if (vld_i)
                s_q <= s_d;
            if (vld_pipe_q[0])
                sq_q <= sq_d;
        end
    end

    assign sq_o  = sq_q;
    assign vld_o = vld_pipe_q[STAGES-1];

endmodule

// File: rtl/eeg_band_power.sv
// Mean-square band power over non-overlapping 2^WIN_LOG2 windows with a
// one-deep ready/valid output and band-activity detect.
// Optional macro BAND_POWER_HYST_EN: alpha_detect uses THRESH_ON/THRESH_OFF
// hysteresis instead of a single threshold.
module eeg_band_power
    import eeg_dsp_pkg::*;
#(
    parameter int                 WIN_LOG2   = 8,
    parameter int                 IN_SHIFT   = 12,
    parameter logic [POWER_W-1:0] THRESH_ON  = 32'h0000_4000,
    parameter logic [POWER_W-1:0] THRESH_OFF = 32'h0000_2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [FILT_W-1:0] filtered_in,
    input  logic                     in_valid,
    output logic [POWER_W-1:0]       power_out,
    output logic                     power_valid,
    input  logic                     power_ready,
    output logic                     alpha_detect,
    output logic                     overrun,
    output logic [WIN_LOG2-1:0]      sample_cnt
);

    localparam int ACC_W = POWER_W + WIN_LOG2;

    logic [POWER_W-1:0]  sq;
    logic                sq_vld;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [1:0]          last_q, last_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [POWER_W-1:0]  res_q, res_d;
    logic                res_vld_q, res_vld_d;
    out_state_e          state_q, state_d;
    logic [POWER_W-1:0]  power_q, power_d;
    logic                alpha_q, alpha_d, detect;
    logic                ovr_q, ovr_d;
    logic                hs;

    bp_square_stage #(.IN_SHIFT(IN_SHIFT)) u_sq (
        .clk_i (clk),
        .rst_i (rst),
        .x_i   (filtered_in),
        .vld_i (in_valid),
        .sq_o  (sq),
        .vld_o (sq_vld)
    );

    // Sample counter at the input; the end-of-window mark rides beside the square pipe.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = {last_q[0], in_valid && (&cnt_q)};
        if (in_valid)
            cnt_d = cnt_q + WIN_LOG2'(1);
    end

    // S3 accumulate; the last sample folds into the result and the next window starts at zero.
    always_comb begin
        sum       = acc_q + ACC_W'(sq);
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        if (sq_vld) begin
            if (last_q[1]) begin
                acc_d     = '0;
                res_d     = POWER_W'(sum >> WIN_LOG2);
                res_vld_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

`ifdef BAND_POWER_HYST_EN
    assign detect = (res_q >= THRESH_ON)  ? 1'b1 :
                    (res_q <  THRESH_OFF) ? 1'b0 : alpha_q;
`else
    logic unused_thresh_off;
    assign unused_thresh_off = ^THRESH_OFF;
    assign detect = (res_q >= THRESH_ON);
`endif

    // Output FSM: a new result replaces the held one only if it is consumed this cycle.
    always_comb begin
        state_d = state_q;
        power_d = power_q;
        alpha_d = alpha_q;
        ovr_d   = ovr_q;
        hs      = (state_q == OUT_FULL) && power_ready;
        if (res_vld_q) begin
            alpha_d = detect;
            if (state_q == OUT_EMPTY || hs) begin
                power_d = res_q;
                state_d = OUT_FULL;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (hs) begin
            state_d = OUT_EMPTY;
        end
    end

    // State registers for counter, accumulator and output side.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            last_q    <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            state_q   <= OUT_EMPTY;
            power_q   <= '0;
            alpha_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            state_q   <= state_d;
            power_q   <= power_d;
            alpha_q   <= alpha_d;
            ovr_q     <= ovr_d;
        end
    end

    assign power_out    = power_q;
    assign power_valid  = (state_q == OUT_FULL);
    assign alpha_detect = alpha_q;
    assign overrun      = ovr_q;
    assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_eeg_band_power.sv
// Scoreboard bench for eeg_band_power with WIN_LOG2=2, IN_SHIFT=12.
module tb_eeg_band_power;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] filtered_in = '0;
    logic        in_valid = 1'b0;
    logic        power_ready = 1'b1;
    logic [31:0] power_out;
    logic        power_valid;
    logic        alpha_detect;
    logic        overrun;
    logic [1:0]  sample_cnt;

    typedef struct {
        logic [31:0] pw;
        logic        al;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef BAND_POWER_HYST_EN
    localparam logic MID_ALPHA = 1'b1;
`else
    localparam logic MID_ALPHA = 1'b0;
`endif

    eeg_band_power #(.WIN_LOG2(2), .IN_SHIFT(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .filtered_in  (filtered_in),
        .in_valid     (in_valid),
        .power_out    (power_out),
        .power_valid  (power_valid),
        .power_ready  (power_ready),
        .alpha_detect (alpha_detect),
        .overrun      (overrun),
        .sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && power_valid && power_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%08h expected none", power_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("power_out", power_out, e.pw);
                chk("alpha_detect", 32'(alpha_detect), 32'(e.al));
            end
        end
    end

    task automatic expect_res(input logic [31:0] pw, input logic al);
        exp_t e;
        e.pw = pw;
        e.al = al;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x);
        filtered_in = x;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
    endtask

    task automatic window(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            tick(1);
            k++;
        end
        chk({nm, "_drain"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_power_out", power_out, 32'd0);
        chk("rst_power_valid", 32'(power_valid), 32'd0);
        chk("rst_alpha", 32'(alpha_detect), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        rst = 1'b0;

        // s=1 per sample, mean 1; also latency of the result.
        expect_res(32'd1, 1'b0);
        send(32'h0000_1000);
        send(32'h0000_1000);
        chk("cnt_mid", 32'(sample_cnt), 32'd2);
        send(32'h0000_1000);
        send(32'h0000_1000);
        chk("cnt_wrap", 32'(sample_cnt), 32'd0);
        tick(2);
        chk("lat_t2_valid", 32'(power_valid), 32'd0);
        tick(1);
        chk("lat_t3_valid", 32'(power_valid), 32'd1);
        drain("unit");

        // Negative saturation and positive saturation.
        expect_res(32'h4000_0000, 1'b1);
        window(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        drain("sat_neg");
        expect_res(32'h3FFF_0001, 1'b1);
        window(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drain("sat_pos");

        // Detect thresholds: s=256,128,0,0 -> 0x5000; 128x3 -> 0x3000; 128 -> 0x1000.
        expect_res(32'h0000_5000, 1'b1);
        window(32'h0010_0000, 32'h0008_0000, 32'h0, 32'h0);
        expect_res(32'h0000_3000, MID_ALPHA);
        window(32'h0008_0000, 32'h0008_0000, 32'h0008_0000, 32'h0);
        expect_res(32'h0000_1000, 1'b0);
        window(32'h0008_0000, 32'h0, 32'h0, 32'h0);
        drain("hyst");
        chk("no_overrun_yet", 32'(overrun), 32'd0);

        // Overrun: second result dropped, first retained, detect follows the dropped one.
        power_ready = 1'b0;
        window(32'h0010_0000, 32'h0008_0000, 32'h0, 32'h0);
        window(32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000);
        tick(6);
        chk("ovr_valid", 32'(power_valid), 32'd1);
        chk("ovr_power_held", power_out, 32'h0000_5000);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_alpha", 32'(alpha_detect), 32'd0);
        expect_res(32'h0000_5000, 1'b0);
        power_ready = 1'b1;
        drain("overrun");

        // Handshake on the same edge a new result arrives.
        power_ready = 1'b0;
        window(32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000);
        tick(5);
        chk("same_first_held", power_out, 32'd4);
        expect_res(32'd4, 1'b0);
        expect_res(32'h4000_0000, 1'b1);
        window(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        tick(2);
        power_ready = 1'b1;
        tick(1);
        chk("same_valid", 32'(power_valid), 32'd1);
        chk("same_new_power", power_out, 32'h4000_0000);
        drain("same_edge");

        // Reset mid-window discards the partial accumulation.
        send(32'h7FFF_FFFF);
        send(32'h7FFF_FFFF);
        chk("pre_rst_cnt", 32'(sample_cnt), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(sample_cnt), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_alpha", 32'(alpha_detect), 32'd0);
        expect_res(32'd4, 1'b0);
        window(32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000);
        drain("post_rst");
        tick(4);
        chk("idle_valid", 32'(power_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
